atm_multi_account_ctrl: RTL and testbench

//  Parametrised ATM session controller. Stores NUM_ACCOUNTS balances and PINs.

---
 rtl/atm_multi_account_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_atm_multi_account_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_multi_account_ctrl.sv
// ATM session controller: per-account balances and PINs, PIN retry limit,
// transaction execution, inactivity timeout and card retention.
module atm_multi_account_ctrl #(
   parameter int               ACCT_W         = 2,
   parameter int               BAL_W          = 32,
   parameter int               AMT_W          = 20,
   parameter int               PIN_W          = 4,
   parameter logic [PIN_W-1:0] DEFAULT_PIN    = 4'b1010,
   parameter int               MAX_TRIES      = 3,
   parameter int               TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cardIn,
   input  logic              ejectCard,
   input  logic [ACCT_W-1:0] accountId,
   input  logic              inputValid,
   input  logic [PIN_W-1:0]  password,
   input  logic [1:0]        opCode,
   input  logic [AMT_W-1:0]  inputAmount,
   output logic              correctPassword,
   output logic [BAL_W-1:0]  Current_Balance,
   output logic              Balance_Shown,
   output logic              Deposited_Successfully,
   output logic              Withdrawed_Successfully,
   output logic              Pin_Changed,
   output logic              Input_Rejected,
   output logic              Timed_Out,
   output logic              cardRetained,
   output logic              ATM_Usage_Finished
);

   localparam int NUM_ACCOUNTS = 1 << ACCT_W;
   localparam int TRY_W        = $clog2(MAX_TRIES + 1);
   localparam int TMR_W        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PIN,
      S_MENU,
      S_EXEC,
      S_DONE,
      S_RETAIN
   } state_t;

   state_t              state, state_n;
   logic [ACCT_W-1:0]   acct, acct_n;
   logic [TRY_W-1:0]    tries, tries_n;
   logic [TMR_W-1:0]    timer, timer_n;
   logic [1:0]          op_q, op_n;
   logic [AMT_W-1:0]    amt_q, amt_n;
   logic [PIN_W-1:0]    pw_q, pw_n;
   logic [BAL_W-1:0]    bal_mem [NUM_ACCOUNTS];
   logic [PIN_W-1:0]    pin_mem [NUM_ACCOUNTS];

   logic [BAL_W-1:0]    cur_bal, amt_ext, bal_wd, cur_bal_n;
   logic [BAL_W:0]      sum;
   logic                bal_we, pin_we;
   logic                shown_n, dep_n, wd_n, pinchg_n, rej_n, tmo_n;

   assign cur_bal = bal_mem[acct];
   assign amt_ext = BAL_W'(amt_q);
   // Extra top bit exposes the deposit carry
   assign sum     = {1'b0, cur_bal} + {1'b0, amt_ext};

   always_comb begin
      state_n  = state;
      acct_n   = acct;
      tries_n  = tries;
      timer_n  = timer;
      op_n     = op_q;
      amt_n    = amt_q;
      pw_n     = pw_q;
      bal_we   = 1'b0;
      bal_wd   = cur_bal;
      pin_we   = 1'b0;
      shown_n  = 1'b0;
      dep_n    = 1'b0;
      wd_n     = 1'b0;
      pinchg_n = 1'b0;
      rej_n    = 1'b0;
      tmo_n    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cardIn) begin
               state_n = S_PIN;
               acct_n  = accountId;
               tries_n = '0;
               timer_n = '0;
            end
         end
         S_PIN, S_MENU: begin
            if (ejectCard || !cardIn) begin
               state_n = S_DONE;
            end else if (inputValid) begin
               timer_n = '0;
               if (state == S_MENU) begin
                  op_n    = opCode;
                  amt_n   = inputAmount;
                  pw_n    = password;
                  state_n = S_EXEC;
               end else if (password == pin_mem[acct]) begin
                  state_n = S_MENU;
               end else begin
                  rej_n   = 1'b1;
                  tries_n = tries + 1'b1;
                  if (tries_n == TRY_W'(MAX_TRIES)) state_n = S_RETAIN;
               end
            end else if (timer == TMR_W'(TIMEOUT_CYCLES - 2)) begin
               tmo_n   = 1'b1;
               state_n = S_DONE;
            end else begin
               timer_n = timer + 1'b1;
            end
         end
         S_EXEC: begin
            state_n = S_MENU;
            timer_n = '0;
            unique case (op_q)
               2'b00: begin
                  pin_we   = 1'b1;
                  pinchg_n = 1'b1;
               end
               2'b01: shown_n = 1'b1;
               2'b10: begin
                  if (amt_q == '0 || sum[BAL_W]) begin
                     rej_n = 1'b1;
                  end else begin
                     bal_we = 1'b1;
                     bal_wd = sum[BAL_W-1:0];
                     dep_n  = 1'b1;
                  end
               end
               2'b11: begin
                  if (amt_q == '0 || amt_ext > cur_bal) begin
                     rej_n = 1'b1;
                  end else begin
                     bal_we = 1'b1;
                     bal_wd = cur_bal - amt_ext;
                     wd_n   = 1'b1;
                  end
               end
            endcase
         end
         S_DONE: begin
            if (!cardIn) state_n = S_IDLE;
         end
         default: ;
      endcase
   end

   // Shows the pre-commit value on the commit edge, the new one a cycle later
   assign cur_bal_n = (state_n == S_MENU || state_n == S_EXEC) ? cur_bal : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                   <= S_IDLE;
         acct                    <= '0;
         tries                   <= '0;
         timer                   <= '0;
         op_q                    <= '0;
         amt_q                   <= '0;
         pw_q                    <= '0;
         for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            bal_mem[i] <= '0;
            pin_mem[i] <= DEFAULT_PIN;
         end
         correctPassword         <= 1'b0;
         Current_Balance         <= '0;
         Balance_Shown           <= 1'b0;
         Deposited_Successfully  <= 1'b0;
         Withdrawed_Successfully <= 1'b0;
         Pin_Changed             <= 1'b0;
         Input_Rejected          <= 1'b0;
         Timed_Out               <= 1'b0;
         cardRetained            <= 1'b0;
         ATM_Usage_Finished      <= 1'b0;
      end else begin
         state                   <= state_n;
         acct                    <= acct_n;
         tries                   <= tries_n;
         timer                   <= timer_n;
         op_q                    <= op_n;
         amt_q                   <= amt_n;
         pw_q                    <= pw_n;
         if (bal_we) bal_mem[acct] <= bal_wd;
         if (pin_we) pin_mem[acct] <= pw_q;
         correctPassword         <= (state_n == S_MENU || state_n == S_EXEC);
         Current_Balance         <= cur_bal_n;
         Balance_Shown           <= shown_n;
         Deposited_Successfully  <= dep_n;
         Withdrawed_Successfully <= wd_n;
         Pin_Changed             <= pinchg_n;
         Input_Rejected          <= rej_n;
         Timed_Out               <= tmo_n;
         cardRetained            <= (state_n == S_RETAIN);
         ATM_Usage_Finished      <= (state_n == S_DONE);
      end
   end

endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// Bench for atm_multi_account_ctrl: directed scenarios plus random sessions
// against an account-level reference model; a BAL_W=8 copy covers overflow.
module tb_atm_multi_account_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        sel;
   logic        cardIn, ejectCard, inputValid;
   logic [1:0]  accountId, opCode;
   logic [3:0]  password;
   logic [19:0] inputAmount;

   logic        a_cp, a_shown, a_dep, a_wd, a_pin, a_rej, a_tmo, a_ret, a_done;
   logic [31:0] a_bal;
   logic        b_cp, b_shown, b_dep, b_wd, b_pin, b_rej, b_tmo, b_ret, b_done;
   logic [7:0]  b_bal;

   logic        o_cp, o_shown, o_dep, o_wd, o_pin, o_rej, o_tmo, o_ret, o_done;
   logic [31:0] o_bal;

   atm_multi_account_ctrl dut (
      .clk(clk), .reset(reset),
      .cardIn(cardIn & ~sel), .ejectCard(ejectCard),
      .accountId(accountId), .inputValid(inputValid & ~sel),
      .password(password), .opCode(opCode), .inputAmount(inputAmount),
      .correctPassword(a_cp), .Current_Balance(a_bal),
      .Balance_Shown(a_shown), .Deposited_Successfully(a_dep),
      .Withdrawed_Successfully(a_wd), .Pin_Changed(a_pin),
      .Input_Rejected(a_rej), .Timed_Out(a_tmo),
      .cardRetained(a_ret), .ATM_Usage_Finished(a_done)
   );

   atm_multi_account_ctrl #(.BAL_W(8), .AMT_W(8)) dut8 (
      .clk(clk), .reset(reset),
      .cardIn(cardIn & sel), .ejectCard(ejectCard),
      .accountId(accountId), .inputValid(inputValid & sel),
      .password(password), .opCode(opCode), .inputAmount(inputAmount[7:0]),
      .correctPassword(b_cp), .Current_Balance(b_bal),
      .Balance_Shown(b_shown), .Deposited_Successfully(b_dep),
      .Withdrawed_Successfully(b_wd), .Pin_Changed(b_pin),
      .Input_Rejected(b_rej), .Timed_Out(b_tmo),
      .cardRetained(b_ret), .ATM_Usage_Finished(b_done)
   );

   assign o_cp    = sel ? b_cp    : a_cp;
   assign o_bal   = sel ? {24'd0, b_bal} : a_bal;
   assign o_shown = sel ? b_shown : a_shown;
   assign o_dep   = sel ? b_dep   : a_dep;
   assign o_wd    = sel ? b_wd    : a_wd;
   assign o_pin   = sel ? b_pin   : a_pin;
   assign o_rej   = sel ? b_rej   : a_rej;
   assign o_tmo   = sel ? b_tmo   : a_tmo;
   assign o_ret   = sel ? b_ret   : a_ret;
   assign o_done  = sel ? b_done  : a_done;

   localparam logic [5:0] P_SHOWN = 6'b100000;
   localparam logic [5:0] P_DEP   = 6'b010000;
   localparam logic [5:0] P_WD    = 6'b001000;
   localparam logic [5:0] P_PIN   = 6'b000100;
   localparam logic [5:0] P_REJ   = 6'b000010;
   localparam logic [5:0] P_TMO   = 6'b000001;

   longint unsigned m_bal [4];
   logic [3:0]      m_pin [4];
   longint unsigned m_lim;
   int              m_acct, m_tries;
   int              checks = 0;
   int              errors = 0;

   function automatic logic [5:0] pulses();
      return {o_shown, o_dep, o_wd, o_pin, o_rej, o_tmo};
   endfunction

   function automatic logic [63:0] all_outs();
      return {23'd0, o_cp, o_bal, pulses(), o_ret, o_done};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cardIn = 0; ejectCard = 0; inputValid = 0;
      accountId = 0; opCode = 0; password = 0; inputAmount = 0;
      reset = 1'b0;
      #2;
      check("reset_outs", all_outs(), 64'd0);
      step();
      reset = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         m_bal[i] = 0;
         m_pin[i] = 4'b1010;
      end
      m_lim = sel ? 64'd256 : 64'd1 << 32;
   endtask

   task automatic insert(input int acct);
      cardIn = 1; accountId = 2'(acct);
      m_acct = acct; m_tries = 0;
      step();
      check("insert_cp", {o_cp, o_done}, 0);
   endtask

   task automatic login(input logic [3:0] p);
      logic ok;
      ok = (p == m_pin[m_acct]);
      inputValid = 1; password = p;
      step();
      inputValid = 0;
      if (!ok) m_tries++;
      check("login_cp", o_cp, ok);
      check("login_rej", o_rej, !ok);
      check("login_ret", o_ret, m_tries >= 3);
      if (ok) check("login_bal", o_bal, m_bal[m_acct]);
   endtask

   task automatic op(input logic [1:0] opc, input logic [19:0] amt,
                     input logic [3:0] pw);
      logic [5:0] exp;
      longint unsigned a;
      a = amt;
      case (opc)
         2'b00: begin exp = P_PIN; m_pin[m_acct] = pw; end
         2'b01: exp = P_SHOWN;
         2'b10: begin
            if (a == 0 || m_bal[m_acct] + a >= m_lim) exp = P_REJ;
            else begin exp = P_DEP; m_bal[m_acct] += a; end
         end
         default: begin
            if (a == 0 || a > m_bal[m_acct]) exp = P_REJ;
            else begin exp = P_WD; m_bal[m_acct] -= a; end
         end
      endcase
      inputValid = 1; opCode = opc; inputAmount = amt; password = pw;
      step();
      inputValid = 0;
      check("op_exec_quiet", {o_cp, pulses()}, {1'b1, 6'd0});
      step();
      check("op_pulse", pulses(), exp);
      step();
      check("op_pulse_clr", pulses(), 0);
      check("op_bal", o_bal, m_bal[m_acct]);
   endtask

   task automatic eject();
      ejectCard = 1;
      step();
      check("eject_done", {o_done, o_cp, o_bal}, {1'b1, 1'b0, 32'd0});
      ejectCard = 0; cardIn = 0;
      step();
      check("idle_outs", all_outs(), 64'd0);
   endtask

   initial begin
      logic [19:0] amt;
      logic [3:0]  wp;
      int          nops;
      sel = 0;
      do_reset();

      // 1-2: deposit then over-withdraw and exact withdraw
      insert(1);
      login(4'b1010);
      op(2'b10, 20'h488, 4'd0);
      check("t1_bal", o_bal, 1160);
      op(2'b11, 20'd1161, 4'd0);
      check("t2_rej_bal", o_bal, 1160);
      op(2'b11, 20'd1160, 4'd0);
      check("t2_zero_bal", o_bal, 0);
      op(2'b01, 20'd0, 4'd0);
      eject();

      // 3: retention after three wrong PINs
      insert(0);
      for (int i = 0; i < 3; i++) login(4'b0001);
      inputValid = 1; password = 4'b1010;
      step();
      inputValid = 0; cardIn = 0;
      step();
      check("t3_ignored", {o_ret, o_cp, o_rej, o_done}, 4'b1000);
      do_reset();
      check("t3_cleared", o_ret, 0);

      // 4: PIN change persists across sessions
      insert(2);
      login(4'b1010);
      op(2'b00, 20'd0, 4'b0110);
      eject();
      insert(2);
      login(4'b1010);
      check("t4_old_rej", o_rej, 1);
      login(4'b0110);
      check("t4_new_cp", o_cp, 1);
      eject();

      // 5: inactivity timeout in MENU
      insert(3);
      login(m_pin[3]);
      repeat (62) step();
      check("t5_pre", {o_tmo, o_cp}, 2'b01);
      step();
      check("t5_fire", {o_tmo, o_done, o_cp}, 3'b110);
      step();
      check("t5_pulse", o_tmo, 0);
      cardIn = 0;
      step();
      check("t5_idle", all_outs(), 64'd0);

      // Random sessions against the account model
      for (int s = 0; s < 40; s++) begin
         insert(int'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) begin
            wp = 4'($urandom_range(1, 15));
            login(m_pin[m_acct] ^ wp);
         end
         login(m_pin[m_acct]);
         nops = int'($urandom_range(1, 5));
         for (int k = 0; k < nops; k++) begin
            case ($urandom_range(0, 3))
               0: amt = 20'd0;
               1: amt = 20'(m_bal[m_acct]);
               2: amt = 20'(m_bal[m_acct] + 1);
               default: amt = 20'($urandom_range(1, 3000));
            endcase
            op(2'($urandom_range(0, 3)), amt, 4'($urandom));
         end
         eject();
      end

      // 6: 8-bit balance overflow and eject racing a strobe
      sel = 1;
      do_reset();
      insert(0);
      login(4'b1010);
      op(2'b10, 20'd250, 4'd0);
      op(2'b10, 20'd10, 4'd0);
      check("t6_bal", o_bal, 250);
      ejectCard = 1; inputValid = 1; opCode = 2'b10; inputAmount = 20'd1;
      step();
      ejectCard = 0; inputValid = 0;
      check("t6_done", {o_done, o_cp, pulses()}, {2'b10, 6'd0});
      step();
      check("t6_no_exec", pulses(), 0);
      cardIn = 0;
      step();
      check("t6_idle", all_outs(), 64'd0);
      sel = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
